// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared constants for the RV32 core: default register-file geometry,
// the all-zero data word and the register address type.
// Imported by regfile_sb and rf_scoreboard.
package regfile_sb_pkg;

  localparam int RF_DEFAULT_XLEN  = 32;
  localparam int RF_DEFAULT_NREGS = 32;
  localparam int RF_DEFAULT_AW    = $clog2(RF_DEFAULT_NREGS);

  localparam logic [RF_DEFAULT_XLEN-1:0] ZERO_WORD = '0;

  typedef logic [RF_DEFAULT_AW-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard
// Per-register busy (pending writer) tracking for the register file.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_en, issue_rd  destination of an instruction issued this cycle
//   wr_en, wr_addr      writeback that retires a pending writer
//   flush               drop all pending writers
//   busy                registered busy vector (bit 0 always 0)
//   busy_cnt            registered number of set busy bits
// Priority per register: flush > issue > writeback > hold.
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int NREGS = RF_DEFAULT_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             issue_hit, wr_hit;
  logic             set_new, clr_old;

  always_comb begin
    issue_hit = issue_en && (issue_rd != '0);
    wr_hit    = wr_en && (wr_addr != '0);
    busy_d    = busy_q;
    set_new   = 1'b0;
    clr_old   = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else begin
      // A new producer to the same register outranks the writeback.
      if (wr_hit && !(issue_hit && (issue_rd == wr_addr))) begin
        busy_d[wr_addr] = 1'b0;
        clr_old         = busy_q[wr_addr];
      end
      if (issue_hit) begin
        busy_d[issue_rd] = 1'b1;
        set_new          = !busy_q[issue_rd];
      end
    end
    busy_d[0] = 1'b0;

    // Only real transitions move the counter, so it tracks the popcount.
    if (flush) begin
      cnt_d = '0;
    end else begin
      unique case ({set_new, clr_old})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// General-purpose register file with busy scoreboard: two combinational
// read ports, one synchronous write port, x0 hard-wired to zero.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rs1/rs2_addr -> rs1/rs2_data  combinational reads
//   rs1/rs2_busy                  pending-writer flag of the read register
//   wr_en, wr_addr, wr_data       writeback (also clears busy)
//   issue_en, issue_rd            issued destination (sets busy)
//   flush                         clear all busy bits
//   busy_cnt                      number of busy registers
// Optional macro RF_WRITE_BYPASS_EN: forwards a same-cycle writeback to
// matching read ports (data and busy). Undefined: reads see stored state only.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int XLEN  = RF_DEFAULT_XLEN,
  parameter  int NREGS = RF_DEFAULT_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  localparam logic [XLEN-1:0] ZW = XLEN'(ZERO_WORD);

  // Entry 0 is never written and never read, so it reduces to constants.
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy;

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? ZW : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? ZW : regs_q[rs2_addr];
    rs1_busy = busy[rs1_addr];
    rs2_busy = busy[rs2_addr];
`ifdef RF_WRITE_BYPASS_EN
    // Same-cycle writeback forwarding; a simultaneous re-issue of the
    // register keeps its registered busy state.
    if (wr_en && (wr_addr != '0) && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      if (!(issue_en && (issue_rd == rs1_addr))) rs1_busy = 1'b0;
    end
    if (wr_en && (wr_addr != '0) && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      if (!(issue_en && (issue_rd == rs2_addr))) rs2_busy = 1'b0;
    end
`endif
  end

endmodule
